// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue block and the ALU it drives.
// Holds the ALU operation encoding, the instruction field positions and the FSM states.
// Optional feature macro used by the other files: ALU_ISSUE_FLAGS_EN.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_OR  = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3,
    ALU_NOT = 4'd4,
    ALU_NEG = 4'd5,
    ALU_ASR = 4'd6,
    ALU_LSL = 4'd7
  } alu_operation_e;

  localparam logic [3:0] OP_LDI = 4'd8;

  // Instruction field positions: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  // Opcodes 0-7 go through the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op < OP_LDI;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction handshake, ALU operand/result and debug read signals.
// master: the alu_issue block; slave: instruction source, ALU and debug observer.
// flags_o exists only when ALU_ISSUE_FLAGS_EN is defined.
interface alu_issue_if #(
  parameter int Width = 16
);
  import alu_issue_pkg::*;

  logic                 instr_valid_i;
  logic                 instr_ready_o;
  logic [15:0]          instr_i;
  logic [Width-1:0]     alu_a_o;
  logic [Width-1:0]     alu_b_o;
  alu_operation_e       alu_op_o;
  logic [Width-1:0]     alu_result_i;
  logic                 done_o;
  logic                 err_o;
  logic [2:0]           dbg_addr_i;
  logic [Width-1:0]     dbg_data_o;
`ifdef ALU_ISSUE_FLAGS_EN
  logic [1:0]           flags_o;
`endif

  modport master (
    input  instr_valid_i, instr_i, alu_result_i, dbg_addr_i,
    output instr_ready_o, alu_a_o, alu_b_o, alu_op_o, done_o, err_o, dbg_data_o
`ifdef ALU_ISSUE_FLAGS_EN
    , output flags_o
`endif
  );

  modport slave (
    output instr_valid_i, instr_i, alu_result_i, dbg_addr_i,
    input  instr_ready_o, alu_a_o, alu_b_o, alu_op_o, done_o, err_o, dbg_data_o
`ifdef ALU_ISSUE_FLAGS_EN
    , input flags_o
`endif
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// NumRegs x Width register file: two operand read ports, one debug read port, one write port.
// Reads are combinational; a write lands on the rising edge and is readable the next cycle.
// No backpressure; async active-low reset clears every entry to 0.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int Width   = 16,
  parameter int NumRegs = 8,
  localparam int AddrW  = $clog2(NumRegs)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] ra_addr_i,
  output logic [Width-1:0] ra_data_o,
  input  logic [AddrW-1:0] rb_addr_i,
  output logic [Width-1:0] rb_data_o,
  input  logic [AddrW-1:0] dbg_addr_i,
  output logic [Width-1:0] dbg_data_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i
);

  logic [Width-1:0] rf_q [NumRegs];
  logic [Width-1:0] rf_d [NumRegs];

  always_comb begin
    rf_d = rf_q;
    if (we_i) rf_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign ra_data_o  = rf_q[ra_addr_i];
  assign rb_data_o  = rf_q[rb_addr_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issues one 16-bit instruction at a time to an external combinational ALU and writes back the result.
// Handshake in cycle N -> operands on the ALU in N+1 -> write-back with done_o (and err_o) in N+2.
// instr_ready_o is high only in S_IDLE and out of reset, so at most one instruction per 3 cycles.
// Ports: clk_i, rst_ni plain; everything else through alu_issue_if.master (instr, ALU, done/err, debug).
// Optional: ALU_ISSUE_FLAGS_EN adds flags_o = {N, Z} updated on every legal write-back.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int Width   = 16,
  parameter int NumRegs = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  alu_issue_if.master bus
);

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [2:0]     rd_q, rd_d;
  logic [8:0]     imm_q, imm_d;
  logic [Width-1:0] alu_a_q, alu_a_d;
  logic [Width-1:0] alu_b_q, alu_b_d;
  alu_operation_e alu_op_q, alu_op_d;
  logic [Width-1:0] result_q, result_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
`ifdef ALU_ISSUE_FLAGS_EN
  logic [1:0]     flags_q, flags_d;
`endif

  logic             instr_ready;
  logic             handshake;
  logic [3:0]       op_in;
  logic [Width-1:0] rf_a, rf_b;
  logic             rf_we;

  // Ready is forced low during reset even though the state already reads S_IDLE.
  assign instr_ready = (state_q == S_IDLE) && rst_ni;
  assign handshake   = bus.instr_valid_i && instr_ready;
  assign op_in       = bus.instr_i[OP_MSB:OP_LSB];

  // Illegal opcodes (op > LDI) retire without a write.
  assign rf_we = (state_q == S_WB) && (op_q <= OP_LDI);

  // Operand ports are addressed straight from the incoming instruction so the
  // operands can be registered on the handshake edge; the regfile cannot change
  // in S_IDLE, so this is the same value S_EXEC would see.
  alu_issue_regfile #(
    .Width   (Width),
    .NumRegs (NumRegs)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ra_addr_i  (bus.instr_i[RA_MSB:RA_LSB]),
    .ra_data_o  (rf_a),
    .rb_addr_i  (bus.instr_i[RB_MSB:RB_LSB]),
    .rb_data_o  (rf_b),
    .dbg_addr_i (bus.dbg_addr_i),
    .dbg_data_o (bus.dbg_data_o),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (result_q)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d  = S_EXEC;
          op_d     = op_in;
          rd_d     = bus.instr_i[RD_MSB:RD_LSB];
          // The immediate overlaps ra/rb/reserved, so keeping it keeps every field needed.
          imm_d    = bus.instr_i[IMM_MSB:IMM_LSB];
          alu_a_d  = rf_a;
          alu_b_d  = rf_b;
          // LDI and illegal ops leave the ALU on a harmless ADD.
          alu_op_d = is_alu_op(op_in) ? alu_operation_e'(op_in) : ALU_ADD;
        end
      end
      S_EXEC: begin
        state_d  = S_WB;
        result_d = (op_q == OP_LDI) ? Width'($signed(imm_q)) : bus.alu_result_i;
        // done/err are registered, so setting them here makes them pulse in S_WB.
        done_d   = 1'b1;
        err_d    = (op_q > OP_LDI);
      end
      S_WB: begin
        state_d = S_IDLE;
`ifdef ALU_ISSUE_FLAGS_EN
        if (op_q <= OP_LDI) flags_d = {result_q[Width-1], (result_q == '0)};
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_ADD;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      flags_q  <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef ALU_ISSUE_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign bus.instr_ready_o = instr_ready;
  assign bus.alu_a_o       = alu_a_q;
  assign bus.alu_b_o       = alu_b_q;
  assign bus.alu_op_o      = alu_op_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
`ifdef ALU_ISSUE_FLAGS_EN
  assign bus.flags_o       = flags_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: drives instructions, emulates the ALU, compares against an array model.
// Drives inputs and samples outputs on the falling clock edge.
// Covers reset, directed instructions, illegal op, back-to-back issue, random mix and mid-op reset.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_issue_if #(.Width(16)) bus ();

  alu_issue #(.Width(16), .NumRegs(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU semantics, written from the operation definitions.
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a | b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      4'd4: return ~a;
      4'd5: return 16'(0 - int'(a));
      4'd6: return (b >= 16) ? {16{a[15]}} : 16'($signed(a) >>> b[3:0]);
      4'd7: return (b >= 16) ? 16'h0000 : 16'(a << b[3:0]);
      default: return 16'h0000;
    endcase
  endfunction

  // Environment ALU driven by the DUT's operands.
  always_comb bus.alu_result_i = ref_alu(4'(bus.alu_op_o), bus.alu_a_o, bus.alu_b_o);

  // Architectural model.
  logic [15:0] m_rf [8];
  logic [1:0]  m_flags;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_flags = 2'b00;
  endtask

  task automatic model_apply(input logic [15:0] ins, output logic [15:0] res, output logic wr, output logic er);
    int op;
    op = int'(ins[15:12]);
    if (op < 8)       res = ref_alu(ins[15:12], m_rf[ins[8:6]], m_rf[ins[5:3]]);
    else if (op == 8) res = {{7{ins[8]}}, ins[8:0]};
    else              res = 16'h0000;
    wr = (op <= 8);
    er = (op > 8);
    if (wr) begin
      m_rf[ins[11:9]] = res;
      m_flags = {res[15], res == 16'h0000};
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
    return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input logic [8:0] imm);
    return {4'd8, 3'(rd), imm};
  endfunction

  typedef struct packed {
    logic        hs_ok;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        done_exec;
    logic        done_wb;
    logic        err_wb;
    logic        done_after;
    logic [15:0] dbg_wb;
    logic [15:0] dbg_after;
    logic [1:0]  flags_after;
  } obs_t;

  // Drives one instruction through the handshake and samples each phase; no comparisons.
  task automatic issue_obs(input logic [15:0] ins, output obs_t o);
    int w;
    o = '0;
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = ins;
    w = 0;
    while (!bus.instr_ready_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    o.hs_ok = bus.instr_ready_o;
    @(negedge clk);                       // S_EXEC
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = 16'($urandom);
    o.a         = bus.alu_a_o;
    o.b         = bus.alu_b_o;
    o.op        = 4'(bus.alu_op_o);
    o.done_exec = bus.done_o;
    bus.dbg_addr_i = ins[11:9];
    @(negedge clk);                       // S_WB
    o.dbg_wb  = bus.dbg_data_o;
    o.done_wb = bus.done_o;
    o.err_wb  = bus.err_o;
    @(negedge clk);                       // back in S_IDLE
    o.dbg_after  = bus.dbg_data_o;
    o.done_after = bus.done_o;
`ifdef ALU_ISSUE_FLAGS_EN
    o.flags_after = bus.flags_o;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = 16'h0000;
    bus.dbg_addr_i    = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.instr_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low got=%b exp=0", bus.instr_ready_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready_o, bus.done_o, bus.err_o} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl got ready/done/err=%b exp=100", {bus.instr_ready_o, bus.done_o, bus.err_o});
    end
    checks++;
    if ({bus.alu_a_o, bus.alu_b_o, 4'(bus.alu_op_o)} !== 36'h0) begin
      errors++; $display("FAIL reset_alu_out got a=%h b=%h op=%0d exp 0/0/0", bus.alu_a_o, bus.alu_b_o, bus.alu_op_o);
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr_i = 3'(i);
      #1;
      checks++;
      if (bus.dbg_data_o !== 16'h0000) begin
        errors++; $display("FAIL reset_rf[%0d] got=%h exp=0000", i, bus.dbg_data_o);
      end
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if (bus.flags_o !== 2'b00) begin
      errors++; $display("FAIL reset_flags got=%b exp=00", bus.flags_o);
    end
`endif
  endtask

  task automatic test_directed();
    obs_t o;
    logic [15:0] r;
    logic wr, er;
    // LDI r1, 0x1FF
    model_apply(ldi(1, 9'h1FF), r, wr, er);
    issue_obs(ldi(1, 9'h1FF), o);
    checks++;
    if ({o.hs_ok, o.done_exec, o.done_wb, o.err_wb, o.done_after} !== 5'b10100) begin
      errors++; $display("FAIL ldi1_timing got hs/dexec/dwb/err/dafter=%b exp=10100", {o.hs_ok, o.done_exec, o.done_wb, o.err_wb, o.done_after});
    end
    checks++;
    if (o.dbg_after !== 16'hFFFF) begin errors++; $display("FAIL ldi1_value got=%h exp=ffff", o.dbg_after); end
    checks++;
    if (o.op !== 4'd0) begin errors++; $display("FAIL ldi1_aluop got=%0d exp=0", o.op); end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if (o.flags_after !== 2'b10) begin errors++; $display("FAIL ldi1_flags got=%b exp=10", o.flags_after); end
`endif
    // LDI r2, 5
    model_apply(ldi(2, 9'h005), r, wr, er);
    issue_obs(ldi(2, 9'h005), o);
    checks++;
    if (o.dbg_after !== 16'h0005) begin errors++; $display("FAIL ldi2_value got=%h exp=0005", o.dbg_after); end
    // ADD r3, r1, r2
    model_apply(enc(0, 3, 1, 2), r, wr, er);
    issue_obs(enc(0, 3, 1, 2), o);
    checks++;
    if ({o.a, o.b, o.op} !== {16'hFFFF, 16'h0005, 4'd0}) begin
      errors++; $display("FAIL add_operands got a=%h b=%h op=%0d exp a=ffff b=0005 op=0", o.a, o.b, o.op);
    end
    checks++;
    if (o.dbg_after !== 16'h0004) begin errors++; $display("FAIL add_value got=%h exp=0004", o.dbg_after); end
    // ASR r4, r1, r2
    model_apply(enc(6, 4, 1, 2), r, wr, er);
    issue_obs(enc(6, 4, 1, 2), o);
    checks++;
    if (o.dbg_after !== 16'hFFFF) begin errors++; $display("FAIL asr_value got=%h exp=ffff", o.dbg_after); end
    // LSL r5, r2, r2
    model_apply(enc(7, 5, 2, 2), r, wr, er);
    issue_obs(enc(7, 5, 2, 2), o);
    checks++;
    if ({o.op, o.dbg_after} !== {4'd7, 16'h00A0}) begin
      errors++; $display("FAIL lsl_value got op=%0d val=%h exp op=7 val=00a0", o.op, o.dbg_after);
    end
    // ADD r2, r2, r2 (rd == ra == rb)
    model_apply(enc(0, 2, 2, 2), r, wr, er);
    issue_obs(enc(0, 2, 2, 2), o);
    checks++;
    if ({o.dbg_wb, o.dbg_after} !== {16'h0005, 16'h000A}) begin
      errors++; $display("FAIL add_rd_eq_ra got wb=%h after=%h exp wb=0005 after=000a", o.dbg_wb, o.dbg_after);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [15:0] r;
    logic wr, er;
    model_apply(ldi(6, 9'h180), r, wr, er);     // r6 = 0xFF80, flags N=1
    issue_obs(ldi(6, 9'h180), o);
    model_apply({4'hC, 3'd6, 9'h1AB}, r, wr, er);
    issue_obs({4'hC, 3'd6, 9'h1AB}, o);
    checks++;
    if ({o.done_exec, o.done_wb, o.err_wb, o.done_after} !== 4'b0110) begin
      errors++; $display("FAIL illegal_pulse got dexec/dwb/err/dafter=%b exp=0110", {o.done_exec, o.done_wb, o.err_wb, o.done_after});
    end
    checks++;
    if (o.dbg_after !== 16'hFF80) begin errors++; $display("FAIL illegal_no_write got=%h exp=ff80", o.dbg_after); end
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL illegal_err_clear got=%b exp=0", bus.err_o); end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if (o.flags_after !== 2'b10) begin errors++; $display("FAIL illegal_flags_held got=%b exp=10", o.flags_after); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [9];
    logic        exp_err [9];
    int          hs_cyc[$];
    int          done_cyc[$];
    logic        err_seen[$];
    logic [15:0] r;
    logic        wr, er, hs;
    int          idx;
    for (int i = 0; i < 9; i++) begin
      prog[i] = 16'($urandom);
      if (i % 3 == 0) prog[i][15:12] = 4'(i % 9);      // make sure several legal ops appear
      model_apply(prog[i], r, wr, er);
      exp_err[i] = er;
    end
    idx = 0;
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = prog[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (bus.done_o) begin
        done_cyc.push_back(cyc);
        err_seen.push_back(bus.err_o);
      end
      hs = bus.instr_valid_i && bus.instr_ready_o;
      if (hs) hs_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 9) bus.instr_i = prog[idx];
        else         bus.instr_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (hs_cyc.size() != 9 || done_cyc.size() != 9) begin
      errors++; $display("FAIL b2b_count got hs=%0d done=%0d exp 9/9", hs_cyc.size(), done_cyc.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (done_cyc[i] - hs_cyc[i] != 2 || err_seen[i] !== exp_err[i]) begin
          errors++; $display("FAIL b2b_done[%0d] got lat=%0d err=%b exp lat=2 err=%b", i, done_cyc[i] - hs_cyc[i], err_seen[i], exp_err[i]);
        end
        if (i < 8) begin
          checks++;
          if (hs_cyc[i+1] - hs_cyc[i] != 3) begin
            errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", i, hs_cyc[i+1] - hs_cyc[i]);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr_i = 3'(i);
      #1;
      checks++;
      if (bus.dbg_data_o !== m_rf[i]) begin
        errors++; $display("FAIL b2b_rf[%0d] got=%h exp=%h", i, bus.dbg_data_o, m_rf[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] ins, r, ea, eb, old;
    logic wr, er;
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd8;
      ea  = m_rf[ins[8:6]];
      eb  = m_rf[ins[5:3]];
      old = m_rf[ins[11:9]];
      model_apply(ins, r, wr, er);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue_obs(ins, o);
      checks++;
      if ({o.hs_ok, o.a, o.b} !== {1'b1, ea, eb}) begin
        errors++; $display("FAIL rnd_operands[%0d] ins=%h got hs=%b a=%h b=%h exp a=%h b=%h", n, ins, o.hs_ok, o.a, o.b, ea, eb);
      end
      if (!er) begin
        checks++;
        if (o.op !== ((ins[15:12] == 4'd8) ? 4'd0 : ins[15:12])) begin
          errors++; $display("FAIL rnd_aluop[%0d] ins=%h got=%0d", n, ins, o.op);
        end
      end
      checks++;
      if ({o.done_exec, o.done_wb, o.err_wb, o.done_after} !== {1'b0, 1'b1, er, 1'b0}) begin
        errors++; $display("FAIL rnd_done[%0d] ins=%h got=%b exp=%b", n, ins, {o.done_exec, o.done_wb, o.err_wb, o.done_after}, {1'b0, 1'b1, er, 1'b0});
      end
      checks++;
      if ({o.dbg_wb, o.dbg_after} !== {old, m_rf[ins[11:9]]}) begin
        errors++; $display("FAIL rnd_result[%0d] ins=%h got wb=%h after=%h exp wb=%h after=%h", n, ins, o.dbg_wb, o.dbg_after, old, m_rf[ins[11:9]]);
      end
`ifdef ALU_ISSUE_FLAGS_EN
      checks++;
      if (o.flags_after !== m_flags) begin
        errors++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", n, o.flags_after, m_flags);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [15:0] r;
    logic wr, er;
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = ldi(7, 9'h0AA);
    @(negedge clk);                           // in S_EXEC
    bus.instr_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.instr_ready_o, bus.done_o, bus.alu_a_o, 4'(bus.alu_op_o)} !== 22'h0) begin
      errors++; $display("FAIL midrst_during got ready=%b done=%b a=%h op=%0d exp all 0", bus.instr_ready_o, bus.done_o, bus.alu_a_o, bus.alu_op_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.done_o, bus.err_o, bus.instr_ready_o} !== 3'b001) begin
        errors++; $display("FAIL midrst_after[%0d] got done/err/ready=%b exp=001", c, {bus.done_o, bus.err_o, bus.instr_ready_o});
      end
    end
    bus.dbg_addr_i = 3'd7;
    #1;
    checks++;
    if (bus.dbg_data_o !== 16'h0000) begin errors++; $display("FAIL midrst_no_write got=%h exp=0000", bus.dbg_data_o); end
    model_apply(ldi(7, 9'h033), r, wr, er);
    issue_obs(ldi(7, 9'h033), o);
    checks++;
    if ({o.done_wb, o.dbg_after} !== {1'b1, 16'h0033}) begin
      errors++; $display("FAIL midrst_recover got done=%b val=%h exp 1/0033", o.done_wb, o.dbg_after);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
